fc2_weight_loader: RTL and testbench
====================================

# fc2_weight_loader

Runtime writer for the fc2 layer weights: accepts a valid/ready stream of 16-bit weights in the same word order as the fc2 weight `.mem` image and stores them in an internal 256-entry array. Presents the same packed read port the fc2 datapath already consumes, with all 16 neuron weights for one input feature on one 256-bit word. Lets the host reload weights without resynthesis; sits between the host/DMA stream and the fc2 MAC array.

## Interface
Parameters:
- NUM_FEATURES, 16, number of input features (rows of the packed read port)
- NUM_NEURONS, 16, neurons per feature (lanes per packed word)
- WEIGHT_WIDTH, 16, bits per weight
- ADDR_WIDTH, $clog2(NUM_FEATURES) = 4, read address width
- DATA_WIDTH, NUM_NEURONS*WEIGHT_WIDTH = 256, packed read width
- DEPTH, NUM_FEATURES*NUM_NEURONS = 256, total weights per load

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepting words
- s_data  in  WEIGHT_WIDTH  weight word
- s_last  in  1  marks final word of a load
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful load
- error  out  1  level; load ended with a framing error
- weights_valid  out  1  level; array holds a complete good load
- rd_addr  in  ADDR_WIDTH  input-feature index
- rd_data  out  DATA_WIDTH  packed weights for rd_addr

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE/DONE/ERR + start -> LOAD; wr_ptr <= 0, weights_valid <= 0, error <= 0.
- start while in LOAD is ignored.
- LOAD: s_ready = 1; beat accepted when s_valid & s_ready. Accepted word k written to mem[k]; wr_ptr increments by 1.
- Accepted beat with wr_ptr == DEPTH-1: s_last=1 -> DONE (done pulses 1 cycle, weights_valid <= 1); s_last=0 -> ERR.
- Accepted beat with wr_ptr < DEPTH-1 and s_last=1 -> ERR (early last); that word is still written.
- ERR: error=1, weights_valid=0 until next start. Beats are not accepted outside LOAD.
- Word order: stream word k is neuron (NUM_NEURONS-1 - k%NUM_NEURONS) of feature k/NUM_NEURONS. Read lane i = rd_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[rd_addr*NUM_NEURONS + (NUM_NEURONS-1-i)]. First word of each 16-word group lands in the top lane.
- rd_addr >= NUM_FEATURES is out of contract (default config covers all 4-bit values).
- Consumers use rd_data only while weights_valid=1; rd_data during LOAD/ERR reflects partial contents.

## Timing
- Reset values: state IDLE, wr_ptr 0, s_ready 0, busy 0, done 0, error 0, weights_valid 0. Array contents are not reset.
- s_ready and busy are registered: both 1 from the cycle after start through the cycle the final beat is accepted; 0 the cycle after.
- Write latency 1: word accepted at edge N is visible on rd_data after edge N.
- Read path is combinational from array to rd_data (same as the fc2 ROM it replaces).
- done asserts the cycle after the final accepted beat, for exactly 1 cycle; weights_valid rises the same cycle.
- error asserts the cycle after the offending beat.
- Reset mid-load: immediate return to IDLE, weights_valid 0, partial contents retained but invalid.
- Minimum load time with s_valid held high: 1 + DEPTH cycles from start to done.

## Test plan
- Reset, start, stream k=0..255 with s_data=k, s_last on k=255, no gaps -> done pulses once 257 cycles after start; rd_addr=0 gives lane15=0x0000, lane0=0x000F; rd_addr=15 gives lane15=0x00F0, lane0=0x00FF; weights_valid=1.
- Same load with s_valid randomly deasserted ~50% -> identical array contents; wr_ptr advances only on handshakes; done after the 256th beat.
- s_last on beat k=10 -> error=1 next cycle, weights_valid=0, s_ready=0; further s_valid beats not accepted.
- 256 beats with s_last=0 on the last -> error=1, no done pulse.
- rst asserted after 100 beats -> s_ready, busy, weights_valid drop immediately; new start plus full load of value 0xA5A5 -> all lanes of every row read 0xA5A5.
- After a good load, start again -> weights_valid falls next cycle; second full load of ~k completes with done; start pulsed during LOAD has no effect.

Source files
------------

// File: rtl/fc2_weight_loader_if.sv
// rtl/fc2_weight_loader_if.sv - weight stream handshake bundle for fc2_weight_loader
interface fc2_weight_loader_if #(
    parameter int WEIGHT_WIDTH = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic [WEIGHT_WIDTH-1:0] s_data;
    logic                    s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fc2_weight_loader.sv
// rtl/fc2_weight_loader.sv - streamed runtime loader for the fc2 packed weight array
module fc2_weight_loader #(
    parameter int NUM_FEATURES = 16,
    parameter int NUM_NEURONS  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_WIDTH   = $clog2(NUM_FEATURES),
    parameter int DATA_WIDTH   = NUM_NEURONS * WEIGHT_WIDTH,
    parameter int DEPTH        = NUM_FEATURES * NUM_NEURONS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    fc2_weight_loader_if.slave    s,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  weights_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]              state;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    ready_q;
    logic                    accept;
    logic                    at_end;
    logic [WEIGHT_WIDTH-1:0] mem [DEPTH];

    assign s.s_ready = ready_q;
    assign accept    = s.s_valid & ready_q;
    assign at_end    = (wr_ptr == PTR_W'(DEPTH - 1));

    // Control FSM: framing of a load, handshake and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            ready_q       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            weights_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (at_end || s.s_last) begin
                            ready_q <= 1'b0;
                            busy    <= 1'b0;
                            if (at_end && s.s_last) begin
                                state         <= DONE;
                                done          <= 1'b1;
                                weights_valid <= 1'b1;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all restart a fresh load on start
                    if (start) begin
                        state         <= LOAD;
                        wr_ptr        <= '0;
                        ready_q       <= 1'b1;
                        busy          <= 1'b1;
                        error         <= 1'b0;
                        weights_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Weight array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= s.s_data;
        end
    end

    // Packed read: first word of each group of NUM_NEURONS lands in the top lane
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            rd_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                mem[PTR_W'(rd_addr) * PTR_W'(NUM_NEURONS) + PTR_W'(NUM_NEURONS - 1 - i)];
        end
    end
endmodule

// File: tb/tb_fc2_weight_loader.sv
// tb/tb_fc2_weight_loader.sv - directed self-checking bench for fc2_weight_loader
module tb_fc2_weight_loader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, error, weights_valid;
    logic [3:0]   rd_addr = '0;
    logic [255:0] rd_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int edges;
    int dc;

    fc2_weight_loader_if #(.WEIGHT_WIDTH(16)) sif ();

    fc2_weight_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s             (sif.slave),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .weights_valid (weights_valid),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic logic [15:0] val(input int mode, input int k);
        logic [15:0] kk;
        kk = k[15:0];
        case (mode)
            0:       return kk;
            1:       return 16'hA5A5;
            2:       return ~kk;
            default: return 16'h1000 + kk;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams n beats; start_at >= 0 re-pulses start alongside that beat
    task automatic stream(input int n, input int mode, input int last_idx,
                          input bit gaps, input int start_at, output int ne);
        int  k = 0;
        int  guard = 0;
        bit  acc;
        ne = 0;
        while (k < n && guard < 4000) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                sif.s_valid = 1'b0;
            end else begin
                sif.s_valid = 1'b1;
                sif.s_data  = val(mode, k);
                sif.s_last  = (k == last_idx);
            end
            start = (k == start_at);
            acc = sif.s_valid && sif.s_ready;
            tick();
            ne++;
            guard++;
            if (acc) k++;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        start = 1'b0;
        chk("stream_beats", k, n);
    endtask

    task automatic check_rows(input int mode);
        for (int r = 0; r < 16; r++) begin
            tick();
            rd_addr = r[3:0];
            #1;
            for (int i = 0; i < 16; i++)
                chk($sformatf("row%0d_lane%0d", r, i), rd_data[i*16 +: 16], val(mode, r*16 + 15 - i));
        end
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;

        // Reset state
        tick();
        chk("rst_s_ready", sif.s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wv", weights_valid, 0);
        tick();
        rst = 1'b0;

        // Gapless load of k
        pulse_start();
        chk("load_s_ready", sif.s_ready, 1);
        chk("load_busy", busy, 1);
        stream(256, 0, 255, 1'b0, -1, edges);
        chk("t1_edges", edges, 256);
        chk("t1_done", done, 1);
        chk("t1_wv", weights_valid, 1);
        chk("t1_s_ready_low", sif.s_ready, 0);
        chk("t1_busy_low", busy, 0);
        rd_addr = 4'd0;
        #1;
        chk("t1_a0_l15", rd_data[15*16 +: 16], 16'h0000);
        chk("t1_a0_l0", rd_data[15:0], 16'h000F);
        rd_addr = 4'd15;
        #1;
        chk("t1_a15_l15", rd_data[15*16 +: 16], 16'h00F0);
        chk("t1_a15_l0", rd_data[15:0], 16'h00FF);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_done_cnt", done_cnt, 1);
        check_rows(0);

        // Same load with random valid gaps
        pulse_start();
        stream(256, 0, 255, 1'b1, -1, edges);
        chk("t2_done", done, 1);
        chk("t2_wv", weights_valid, 1);
        checks++;
        assert (edges > 256) else begin
            errors++;
            $error("FAIL t2_gaps: observed %0d edges expected more than 256", edges);
        end
        check_rows(0);

        // Early s_last on beat 10
        pulse_start();
        chk("t3_wv_cleared", weights_valid, 0);
        stream(11, 3, 10, 1'b0, -1, edges);
        chk("t3_error", error, 1);
        chk("t3_wv", weights_valid, 0);
        chk("t3_s_ready", sif.s_ready, 0);
        chk("t3_done", done, 0);
        sif.s_valid = 1'b1;
        sif.s_data  = 16'hDEAD;
        repeat (3) tick();
        sif.s_valid = 1'b0;
        rd_addr = 4'd0;
        #1;
        chk("t3_l15", rd_data[15*16 +: 16], 16'h1000);
        chk("t3_l5", rd_data[5*16 +: 16], 16'h100A);
        chk("t3_l4_kept", rd_data[4*16 +: 16], 16'h000B);
        chk("t3_error_held", error, 1);

        // Full 256 beats without s_last
        dc = done_cnt;
        pulse_start();
        chk("t4_error_cleared", error, 0);
        stream(256, 0, -1, 1'b0, -1, edges);
        chk("t4_error", error, 1);
        chk("t4_wv", weights_valid, 0);
        tick();
        chk("t4_no_done", done_cnt, dc);

        // Reset after 100 beats, then constant reload
        pulse_start();
        stream(100, 2, -1, 1'b0, -1, edges);
        rst = 1'b1;
        #1;
        chk("t5_s_ready", sif.s_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_wv", weights_valid, 0);
        tick();
        rst = 1'b0;
        pulse_start();
        stream(256, 1, 255, 1'b0, -1, edges);
        chk("t5_done", done, 1);
        chk("t5_wv_set", weights_valid, 1);
        check_rows(1);

        // Reload of ~k with a stray start mid-load
        dc = done_cnt;
        pulse_start();
        chk("t6_wv_fall", weights_valid, 0);
        stream(256, 2, 255, 1'b0, 50, edges);
        chk("t6_edges", edges, 256);
        chk("t6_done", done, 1);
        tick();
        chk("t6_done_cnt", done_cnt, dc + 1);
        rd_addr = 4'd3;
        #1;
        chk("t6_a3_l0", rd_data[15:0], 16'hFFC0);
        check_rows(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
